// File: rtl/cdb_slot_scheduler.sv
// Common data bus slot scheduler: reserves future CDB cycles for fixed-latency
// MUL/DIV results and arbitrates free cycles round-robin between ALU and LS.
module cdb_slot_scheduler #(
    parameter int MUL_LAT    = 4,
    parameter int DIV_LAT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_req,
    input  logic       ls_req,
    input  logic       mul_req,
    input  logic       div_req,
    output logic       alu_gnt,
    output logic       ls_gnt,
    output logic       mul_gnt,
    output logic       div_gnt,
    output logic       cdb_valid,
    output logic [1:0] cdb_sel,
    output logic       div_busy
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LS  = 1'b1
    } rr_ptr_t;

    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIM);

    // slot_valid[k] marks the CDB owned k cycles from now; slot_div[k] names DIV as owner
    logic [DIV_LAT-1:0] slot_valid;
    logic [DIV_LAT-1:0] slot_div;
    logic [DIV_LAT-1:0] slot_valid_next;
    logic [DIV_LAT-1:0] slot_div_next;
    rr_ptr_t            rr_ptr;
    rr_ptr_t            rr_ptr_next;
    logic [3:0]         starve_cnt;
    logic [3:0]         starve_cnt_next;
    logic               div_busy_next;
    logic               throttle;
    logic               cdb_reserved;

    always_comb begin
        alu_gnt         = 1'b0;
        ls_gnt          = 1'b0;
        cdb_sel         = 2'd0;
        rr_ptr_next     = rr_ptr;
        starve_cnt_next = starve_cnt;

        cdb_reserved = slot_valid[0];
        throttle     = (starve_cnt >= STARVE_THR);

        if (!cdb_reserved) begin
            if (alu_req && ls_req) begin
                alu_gnt = (rr_ptr == PTR_ALU);
                ls_gnt  = (rr_ptr == PTR_LS);
            end else begin
                alu_gnt = alu_req;
                ls_gnt  = ls_req;
            end
        end

        // Slot DIV_LAT is never reserved by anyone, so only the busy flag gates DIV.
        mul_gnt = mul_req && !slot_valid[MUL_LAT] && !throttle;
        div_gnt = div_req && !div_busy && !throttle;

        cdb_valid = cdb_reserved || alu_gnt || ls_gnt;
        if (cdb_reserved) begin
            cdb_sel = slot_div[0] ? 2'd3 : 2'd2;
        end else if (ls_gnt) begin
            cdb_sel = 2'd1;
        end

        slot_valid_next = {div_gnt, slot_valid[DIV_LAT-1:1]};
        slot_div_next   = {div_gnt, slot_div[DIV_LAT-1:1]};
        if (mul_gnt) begin
            slot_valid_next[MUL_LAT-1] = 1'b1;
            slot_div_next[MUL_LAT-1]   = 1'b0;
        end

        if (alu_gnt) begin
            rr_ptr_next = PTR_LS;
        end else if (ls_gnt) begin
            rr_ptr_next = PTR_ALU;
        end

        if (alu_gnt || ls_gnt || !(alu_req || ls_req)) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt != 4'hf) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end

        // Busy drops as the DIV result reaches slot 0, letting a new DIV issue that cycle.
        div_busy_next = div_gnt || (div_busy && !(slot_valid[1] && slot_div[1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            slot_div   <= '0;
            rr_ptr     <= PTR_ALU;
            starve_cnt <= 4'd0;
            div_busy   <= 1'b0;
        end else begin
            slot_valid <= slot_valid_next;
            slot_div   <= slot_div_next;
            rr_ptr     <= rr_ptr_next;
            starve_cnt <= starve_cnt_next;
            div_busy   <= div_busy_next;
        end
    end

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Scoreboard bench for cdb_slot_scheduler: an absolute-time reservation model
// predicts every output per cycle; predictions are queued and compared.
module tb_cdb_slot_scheduler;

    localparam int MUL_LAT    = 4;
    localparam int DIV_LAT    = 16;
    localparam int STARVE_LIM = 4;
    localparam int HORIZON    = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_req = 1'b0;
    logic       ls_req = 1'b0;
    logic       mul_req = 1'b0;
    logic       div_req = 1'b0;
    logic       alu_gnt, ls_gnt, mul_gnt, div_gnt, cdb_valid, div_busy;
    logic [1:0] cdb_sel;

    cdb_slot_scheduler #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_req(alu_req),
        .ls_req(ls_req),
        .mul_req(mul_req),
        .div_req(div_req),
        .alu_gnt(alu_gnt),
        .ls_gnt(ls_gnt),
        .mul_gnt(mul_gnt),
        .div_gnt(div_gnt),
        .cdb_valid(cdb_valid),
        .cdb_sel(cdb_sel),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ag;
        logic       lg;
        logic       mg;
        logic       dg;
        logic       cv;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    // Model state: owner per absolute cycle (0 free, 2 MUL, 3 DIV)
    logic [1:0] resAt[HORIZON];
    int         mt;
    int         divEnd;
    int         mPtr;
    int         mCnt;

    task automatic modelReset();
        for (int i = 0; i < HORIZON; i++) resAt[i] = 2'd0;
        mt     = 0;
        divEnd = 0;
        mPtr   = 0;
        mCnt   = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic modelStep(input logic a, input logic l, input logic m, input logic d, output exp_t e);
        logic thr;
        e.ag   = 1'b0;
        e.lg   = 1'b0;
        e.sel  = 2'd0;
        e.busy = (mt < divEnd);
        thr    = (mCnt >= STARVE_LIM);
        if (resAt[mt] != 2'd0) begin
            e.cv  = 1'b1;
            e.sel = resAt[mt];
        end else begin
            if (a && l) begin
                e.ag = (mPtr == 0);
                e.lg = (mPtr == 1);
            end else begin
                e.ag = a;
                e.lg = l;
            end
            e.cv  = e.ag | e.lg;
            e.sel = e.lg ? 2'd1 : 2'd0;
        end
        e.mg = m && (resAt[mt + MUL_LAT] == 2'd0) && !thr;
        e.dg = d && !e.busy && (resAt[mt + DIV_LAT] == 2'd0) && !thr;
        if (e.mg) resAt[mt + MUL_LAT] = 2'd2;
        if (e.dg) begin
            resAt[mt + DIV_LAT] = 2'd3;
            divEnd = mt + DIV_LAT;
        end
        if (e.ag) mPtr = 1;
        else if (e.lg) mPtr = 0;
        if (e.ag || e.lg || !(a || l)) mCnt = 0;
        else if (mCnt < 15) mCnt = mCnt + 1;
        mt++;
    endtask

    task automatic applyStimulus(input logic a, input logic l, input logic m, input logic d);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        alu_req = a;
        ls_req  = l;
        mul_req = m;
        div_req = d;
        modelStep(a, l, m, d, e);
        expQ.push_back(e);
        @(negedge clk);
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard empty at t=%0t: got 0 entries expected 1", $time);
        end else begin
            got = expQ.pop_front();
            checkOutput("alu_gnt", {3'b0, alu_gnt}, {3'b0, got.ag});
            checkOutput("ls_gnt", {3'b0, ls_gnt}, {3'b0, got.lg});
            checkOutput("mul_gnt", {3'b0, mul_gnt}, {3'b0, got.mg});
            checkOutput("div_gnt", {3'b0, div_gnt}, {3'b0, got.dg});
            checkOutput("cdb_valid", {3'b0, cdb_valid}, {3'b0, got.cv});
            checkOutput("cdb_sel", {2'b0, cdb_sel}, {2'b0, got.sel});
            checkOutput("div_busy", {3'b0, div_busy}, {3'b0, got.busy});
        end
    endtask

    // Reset is sampled at the next edge; the following applyStimulus drops it.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        alu_req = 1'b0;
        ls_req  = 1'b0;
        mul_req = 1'b0;
        div_req = 1'b0;
        modelReset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_cdb_valid", {3'b0, cdb_valid}, 4'd0);
        checkOutput("reset_div_busy", {3'b0, div_busy}, 4'd0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(17);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(11);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        doReset();
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idle(6);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        idle(4);
        checkOutput("post_reset_cdb_valid", {3'b0, cdb_valid}, 4'd0);

        doReset();
        for (int i = 0; i < 450; i++) begin
            if (i % 150 == 149) doReset();
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        idle(DIV_LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
